// File: rtl/npc_retire_monitor.sv
// Retire-port monitor: counts retired instructions and run cycles, keeps a ring
// of recent PCs, and raises a sticky halt on ebreak or a commit-stall watchdog.
module npc_retire_monitor #(
    parameter int TRACE_DEPTH = 8,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 64,
    localparam int IDX_W      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1,
    localparam int FILL_W     = $clog2(TRACE_DEPTH + 1),
    localparam int IDLE_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [31:0]      commit_pc,
    input  logic [31:0]      commit_inst,
    input  logic [31:0]      commit_a0,
    input  logic [IDX_W-1:0] trace_idx,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      trace_pc,
    output logic             trace_valid
);

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [1:0]  CODE_NONE   = 2'b00;
    localparam logic [1:0]  CODE_GOOD   = 2'b01;
    localparam logic [1:0]  CODE_BAD    = 2'b10;
    localparam logic [1:0]  CODE_WDOG   = 2'b11;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t              state_reg;
    logic                halt_reg;
    logic [1:0]          halt_code_reg;
    logic [CNT_W-1:0]    inst_count_reg;
    logic [CNT_W-1:0]    cycle_count_reg;
    logic [IDLE_W-1:0]   idle_reg;
    logic [FILL_W-1:0]   fill_reg;
    logic [IDX_W-1:0]    wr_ptr_reg;
    logic [31:0]         ring_mem [TRACE_DEPTH];

    logic                ring_we;
    logic [IDX_W-1:0]    rd_ptr;

    assign ring_we = !reset && (state_reg == RUN) && commit_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= RUN;
            halt_reg        <= 1'b0;
            halt_code_reg   <= CODE_NONE;
            inst_count_reg  <= '0;
            cycle_count_reg <= '0;
            idle_reg        <= '0;
            fill_reg        <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    cycle_count_reg <= cycle_count_reg + 1'b1;
                    if (commit_valid) begin
                        inst_count_reg <= inst_count_reg + 1'b1;
                        wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                        idle_reg       <= '0;
                        if (fill_reg != FILL_W'(TRACE_DEPTH))
                            fill_reg <= fill_reg + 1'b1;
                        // A trap always takes precedence over the watchdog.
                        if (commit_inst == EBREAK_INST) begin
                            state_reg     <= HALTED;
                            halt_reg      <= 1'b1;
                            halt_code_reg <= (commit_a0 == 32'd0) ? CODE_GOOD : CODE_BAD;
                        end
                    end else if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
                        state_reg     <= HALTED;
                        halt_reg      <= 1'b1;
                        halt_code_reg <= CODE_WDOG;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= HALTED;
                    halt_reg  <= 1'b1;
                end
            endcase
        end
    end

    // Ring contents are never reset; fill_reg masks stale entries.
    always_ff @(posedge clock) begin
        if (ring_we)
            ring_mem[wr_ptr_reg] <= commit_pc;
    end

    // Power-of-two depth makes the subtraction wrap modulo TRACE_DEPTH.
    assign rd_ptr      = wr_ptr_reg - IDX_W'(1) - trace_idx;
    assign trace_pc    = ring_mem[rd_ptr];
    assign trace_valid = (FILL_W'(trace_idx) < fill_reg);

    assign halt        = halt_reg;
    assign halt_code   = halt_code_reg;
    assign inst_count  = inst_count_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_npc_retire_monitor.sv
// Directed bench for npc_retire_monitor with TIMEOUT=16 and an 8-entry ring.
module tb_npc_retire_monitor;

    localparam int TRACE_DEPTH = 8;
    localparam int TIMEOUT     = 16;
    localparam int CNT_W       = 64;
    localparam int IDX_W       = 3;

    logic             clk;
    logic             reset;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [31:0]      commit_inst;
    logic [31:0]      commit_a0;
    logic [IDX_W-1:0] trace_idx;
    logic             halt;
    logic [1:0]       halt_code;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] cycle_count;
    logic [31:0]      trace_pc;
    logic             trace_valid;

    int checks = 0;
    int errors = 0;

    npc_retire_monitor #(
        .TRACE_DEPTH(TRACE_DEPTH),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .commit_a0   (commit_a0),
        .trace_idx   (trace_idx),
        .halt        (halt),
        .halt_code   (halt_code),
        .inst_count  (inst_count),
        .cycle_count (cycle_count),
        .trace_pc    (trace_pc),
        .trace_valid (trace_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        commit_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a0);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        commit_a0    = a0;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        commit_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic read_trace(input int idx, input logic [31:0] exp_pc, input logic exp_valid, input string tag);
        trace_idx = IDX_W'(idx);
        #1;
        check({tag, "_valid"}, 64'(trace_valid), 64'(exp_valid));
        if (exp_valid) check({tag, "_pc"}, 64'(trace_pc), 64'(exp_pc));
    endtask

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    initial begin
        reset = 1'b0; commit_valid = 1'b0; commit_pc = '0;
        commit_inst = '0; commit_a0 = '0; trace_idx = '0;
        #2;

        // Reset then idle counting
        do_reset();
        check("rst_halt",  64'(halt), 64'd0);
        check("rst_code",  64'(halt_code), 64'd0);
        check("rst_cycle", cycle_count, 64'd0);
        check("rst_inst",  inst_count, 64'd0);
        idle(5);
        check("idle5_halt",  64'(halt), 64'd0);
        check("idle5_cycle", cycle_count, 64'd5);
        check("idle5_inst",  inst_count, 64'd0);
        read_trace(0, 32'h0, 1'b0, "idle5_idx0");

        // Three commits
        commit(32'h8000_0000, NOP, 32'd0);
        commit(32'h8000_0004, NOP, 32'd0);
        commit(32'h8000_0008, NOP, 32'd0);
        check("c3_inst",  inst_count, 64'd3);
        check("c3_cycle", cycle_count, 64'd8);
        read_trace(0, 32'h8000_0008, 1'b1, "c3_idx0");
        read_trace(1, 32'h8000_0004, 1'b1, "c3_idx1");
        read_trace(2, 32'h8000_0000, 1'b1, "c3_idx2");
        read_trace(3, 32'h0, 1'b0, "c3_idx3");

        // Good trap then frozen state
        commit(32'h8000_000c, EBREAK, 32'd0);
        check("good_halt",  64'(halt), 64'd1);
        check("good_code",  64'(halt_code), 64'd1);
        check("good_inst",  inst_count, 64'd4);
        check("good_cycle", cycle_count, 64'd9);
        commit(32'h8000_0010, NOP, 32'd0);
        commit(32'h8000_0014, EBREAK, 32'd7);
        idle(3);
        check("frz_halt",  64'(halt), 64'd1);
        check("frz_code",  64'(halt_code), 64'd1);
        check("frz_inst",  inst_count, 64'd4);
        check("frz_cycle", cycle_count, 64'd9);
        read_trace(0, 32'h8000_000c, 1'b1, "frz_idx0");

        // Bad trap
        do_reset();
        commit(32'h0000_0200, EBREAK, 32'd5);
        check("bad_halt",  64'(halt), 64'd1);
        check("bad_code",  64'(halt_code), 64'd2);
        check("bad_inst",  inst_count, 64'd1);
        check("bad_cycle", cycle_count, 64'd1);

        // Watchdog fires after exactly TIMEOUT idle cycles
        do_reset();
        idle(TIMEOUT - 1);
        check("wd15_halt",  64'(halt), 64'd0);
        check("wd15_cycle", cycle_count, 64'd15);
        idle(1);
        check("wd16_halt",  64'(halt), 64'd1);
        check("wd16_code",  64'(halt_code), 64'd3);
        check("wd16_cycle", cycle_count, 64'd16);
        idle(2);
        check("wdfrz_cycle", cycle_count, 64'd16);

        // Reset out of HALTED
        do_reset();
        check("rh_halt",  64'(halt), 64'd0);
        check("rh_code",  64'(halt_code), 64'd0);
        check("rh_inst",  inst_count, 64'd0);
        check("rh_cycle", cycle_count, 64'd0);
        read_trace(0, 32'h0, 1'b0, "rh_idx0");

        // Commit on the would-be watchdog cycle wins, idle restarts
        idle(TIMEOUT - 1);
        commit(32'h0000_0300, NOP, 32'd0);
        check("save_halt",  64'(halt), 64'd0);
        check("save_inst",  inst_count, 64'd1);
        check("save_cycle", cycle_count, 64'd16);
        idle(TIMEOUT - 1);
        check("save2_halt", 64'(halt), 64'd0);
        idle(1);
        check("save3_halt", 64'(halt), 64'd1);
        check("save3_code", 64'(halt_code), 64'd3);
        check("save3_cycle", cycle_count, 64'd32);

        // Ebreak on the would-be watchdog cycle is a trap
        do_reset();
        idle(TIMEOUT - 1);
        commit(32'h0000_0400, EBREAK, 32'd0);
        check("ebwd_halt", 64'(halt), 64'd1);
        check("ebwd_code", 64'(halt_code), 64'd1);

        // Ring wrap-around
        do_reset();
        for (int k = 0; k < 10; k++) commit(32'h100 + 32'(4 * k), NOP, 32'd0);
        check("wrap_inst", inst_count, 64'd10);
        read_trace(0, 32'h124, 1'b1, "wrap_idx0");
        read_trace(1, 32'h120, 1'b1, "wrap_idx1");
        read_trace(6, 32'h10c, 1'b1, "wrap_idx6");
        read_trace(7, 32'h108, 1'b1, "wrap_idx7");
        for (int i = 2; i < 6; i++) read_trace(i, 32'h124 - 32'(4 * i), 1'b1, "wrap_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
